// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: data/index types,
// ABI register indices and their reset values.
package regfile_mp_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_REG_DEF = 32;

  typedef logic [XLEN-1:0] data_t;
  typedef logic [4:0]      r_t;

  localparam r_t    ZERO    = 5'd0;
  localparam r_t    SP      = 5'd2;
  localparam r_t    GP      = 5'd3;
  localparam data_t SP_BASE = 32'h8000_1000;
  localparam data_t GP_BASE = 32'h8000_0800;
  localparam data_t NULL    = '0;

  function automatic data_t reset_value(input int idx);
    if (idx == int'(SP))      return SP_BASE;
    else if (idx == int'(GP)) return GP_BASE;
    else                      return NULL;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-side bundle of the register file: write-back ports, operand read ports,
// issue notification and scoreboard debug vector.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int NUM_REG = NUM_REG_DEF,
  parameter int AW      = $clog2(NUM_REG)
);

  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_hazard;
  logic                   iss_valid;
  logic [AW-1:0]          iss_rd;
  logic                   flush;
  logic [NUM_REG-1:0]     pending;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_valid, iss_rd, flush,
    input  rd_data, rd_hazard, pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_valid, iss_rd, flush,
    output rd_data, rd_hazard, pending
  );

endinterface

// File: rtl/regfile_mp_reg_scoreboard.sv
// Single-bit-per-register pending scoreboard: issue sets, writeback clears,
// flush wipes; flags read operands whose producer has not written back yet.
module reg_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int NUM_REG = NUM_REG_DEF,
  parameter int AW      = $clog2(NUM_REG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 flush,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD-1:0]    byp_hit,
  output logic [NUM_REG-1:0]   pending,
  output logic [NUM_RD-1:0]    rd_hazard
);

  logic [NUM_REG-1:0] pend_nxt;

  // Priority rises top to bottom: clear, then set, then flush.
  always_comb begin
    pend_nxt = pending;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) pend_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (iss_valid) pend_nxt[iss_rd] = 1'b1;
    if (flush) pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nxt;
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_haz
    logic [AW-1:0] ra;
    assign ra           = rd_addr[r*AW +: AW];
    assign rd_hazard[r] = rd_en[r] && (ra != '0) && pending[ra] && !byp_hit[r];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// pending-write scoreboard for RAW hazard detection in decode.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int NUM_REG = NUM_REG_DEF,
  parameter int BYPASS  = 1
) (
  input logic        clk,
  input logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NUM_REG);

  // Port count rules out RAM macros; keep the array in flops.
  (* ramstyle = "logic" *) data_t regs [NUM_REG];

  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      byp_hit;

  // Ascending port order lets the highest-index writer win on address clashes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) regs[i] <= reset_value(i);
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] != '0))
          regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0] ra;
    data_t         val;
    logic          hit;

    assign ra = bus.rd_addr[r*AW +: AW];

    always_comb begin
      val = regs[ra];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == ra)) begin
            val = bus.wr_data[w*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
      end
      if (!bus.rd_en[r] || (ra == '0)) begin
        val = NULL;
        hit = 1'b0;
      end
    end

    assign rd_data_c[r*XLEN +: XLEN] = val;
    assign byp_hit[r]                = hit;
  end

  assign bus.rd_data = rd_data_c;

  reg_scoreboard #(
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .NUM_REG(NUM_REG),
    .AW     (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_valid(bus.iss_valid),
    .iss_rd   (bus.iss_rd),
    .flush    (bus.flush),
    .rd_en    (bus.rd_en),
    .rd_addr  (bus.rd_addr),
    .byp_hit  (byp_hit),
    .pending  (bus.pending),
    .rd_hazard(bus.rd_hazard)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (2 read, 2 write, bypass on): directed vector table,
// asynchronous reset check, then random traffic against an array model.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int NR  = 32;
  localparam int AW  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_REG(NR), .AW(AW)) bus ();

  regfile_mp #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_REG(NR), .BYPASS(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  rd_en;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic [1:0]  exp_hz;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t tbl [15];
  int   n_tests = 0;
  int   n_fail  = 0;

  data_t m_reg  [NR];
  bit    m_pend [NR];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic iss, input logic [4:0] iss_rd, input logic fl);
    bus.wr_en     = we;
    bus.wr_addr   = {wa1, wa0};
    bus.wr_data   = {wd1, wd0};
    bus.rd_en     = re;
    bus.rd_addr   = {ra1, ra0};
    bus.iss_valid = iss;
    bus.iss_rd    = iss_rd;
    bus.flush     = fl;
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = NULL;
      m_pend[i] = 1'b0;
    end
    m_reg[SP] = SP_BASE;
    m_reg[GP] = GP_BASE;
  endtask

  initial begin
    logic [1:0]  we, re;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];
    logic        iss, fl;
    logic [4:0]  ird;
    logic [31:0] e_d [2];
    logic [1:0]  e_hz;

    //            we     wa0 wd0            wa1 wd1    re     ra0 ra1 iss ird fl exp_d0        exp_d1         hz     pend
    tbl[0]  = '{2'b00, 0, 0,             0, 0,     2'b11, 2,  3,  0,  0,  0, SP_BASE,      GP_BASE,      2'b00, 0};
    tbl[1]  = '{2'b00, 0, 0,             0, 0,     2'b11, 5,  0,  0,  0,  0, 0,            0,            2'b00, 0};
    tbl[2]  = '{2'b01, 5, 32'hDEAD_BEEF, 0, 0,     2'b01, 5,  5,  0,  0,  0, 32'hDEAD_BEEF, 0,           2'b00, 0};
    tbl[3]  = '{2'b00, 0, 0,             0, 0,     2'b11, 5,  5,  0,  0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0};
    tbl[4]  = '{2'b11, 7, 32'h11,        7, 32'h22, 2'b11, 7, 7,  0,  0,  0, 32'h22,       32'h22,       2'b00, 0};
    tbl[5]  = '{2'b01, 0, 32'h55,        0, 0,     2'b11, 7,  0,  0,  0,  0, 32'h22,       0,            2'b00, 0};
    tbl[6]  = '{2'b00, 0, 0,             0, 0,     2'b11, 0,  7,  1,  9,  0, 0,            32'h22,       2'b00, 0};
    tbl[7]  = '{2'b00, 0, 0,             0, 0,     2'b11, 9,  7,  0,  0,  0, 0,            32'h22,       2'b01, 32'h200};
    tbl[8]  = '{2'b10, 0, 0,             9, 32'h42, 2'b11, 9, 9,  0,  0,  0, 32'h42,       32'h42,       2'b00, 32'h200};
    tbl[9]  = '{2'b01, 4, 32'h44,        0, 0,     2'b11, 9,  4,  1,  4,  0, 32'h42,       32'h44,       2'b00, 0};
    tbl[10] = '{2'b01, 6, 32'h66,        0, 0,     2'b11, 4,  3,  1,  6,  1, 32'h44,       GP_BASE,      2'b01, 32'h10};
    tbl[11] = '{2'b00, 0, 0,             0, 0,     2'b11, 4,  6,  1,  8,  0, 32'h44,       32'h66,       2'b00, 0};
    tbl[12] = '{2'b00, 0, 0,             0, 0,     2'b11, 8,  0,  1,  8,  0, 0,            0,            2'b01, 32'h100};
    tbl[13] = '{2'b01, 8, 32'h88,        0, 0,     2'b11, 8,  8,  0,  0,  0, 32'h88,       32'h88,       2'b00, 32'h100};
    tbl[14] = '{2'b00, 0, 0,             0, 0,     2'b11, 8,  9,  1,  10, 0, 32'h88,       32'h42,       2'b00, 0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].wr_en, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
            tbl[i].rd_en, tbl[i].ra0, tbl[i].ra1, tbl[i].iss, tbl[i].iss_rd, tbl[i].flush);
      #1;
      check("tbl_rd0", i, bus.rd_data[31:0], tbl[i].exp_d0);
      check("tbl_rd1", i, bus.rd_data[63:32], tbl[i].exp_d1);
      check("tbl_hz", i, 32'(bus.rd_hazard), 32'(tbl[i].exp_hz));
      check("tbl_pend", i, bus.pending, tbl[i].exp_pend);
    end

    // Asynchronous reset in the middle of a cycle, checked before any clock edge.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b11, 5, 2, 0, 0, 0);
    #1;
    check("pre_rst_x5", 0, bus.rd_data[31:0], 32'hDEAD_BEEF);
    check("pre_rst_pend", 0, bus.pending, 32'h400);
    #1 rst_n = 1'b0;
    #1;
    check("rst_x5", 0, bus.rd_data[31:0], 32'h0);
    check("rst_x2", 0, bus.rd_data[63:32], SP_BASE);
    check("rst_pend", 0, bus.pending, 32'h0);
    check("rst_hz", 0, 32'(bus.rd_hazard), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      we  = 2'($urandom_range(0, 3));
      re  = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        wa[k] = 5'($urandom_range(0, 7));
        wd[k] = $urandom;
        ra[k] = 5'($urandom_range(0, 7));
      end
      iss = ($urandom_range(0, 9) < 4);
      ird = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 19) == 0);
      drive(we, wa[0], wd[0], wa[1], wd[1], re, ra[0], ra[1], iss, ird, fl);

      for (int r = 0; r < 2; r++) begin
        bit hit;
        hit    = 1'b0;
        e_d[r] = m_reg[ra[r]];
        for (int w = 1; w >= 0; w--) begin
          if (!hit && we[w] && wa[w] == ra[r]) begin
            e_d[r] = wd[w];
            hit    = 1'b1;
          end
        end
        if (!re[r] || ra[r] == 0) begin
          e_d[r] = 0;
          hit    = 1'b0;
        end
        e_hz[r] = re[r] && ra[r] != 0 && m_pend[ra[r]] && !hit;
      end

      #1;
      check("rnd_rd0", c, bus.rd_data[31:0], e_d[0]);
      check("rnd_rd1", c, bus.rd_data[63:32], e_d[1]);
      check("rnd_hz", c, 32'(bus.rd_hazard), 32'(e_hz));
      check("rnd_pend", c, bus.pending, pend_vec());

      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w] != 0) m_reg[wa[w]] = wd[w];
        if (we[w]) m_pend[wa[w]] = 1'b0;
      end
      if (iss && ird != 0) m_pend[ird] = 1'b1;
      if (fl) for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
